// File: rtl/fetch_pkg.sv
// Shared constants and the fetch entry type for the instruction-fetch front end.
package fetch_pkg;

    localparam int unsigned       ADDR_W      = 8;
    localparam int unsigned       INSTR_W     = 8;
    localparam logic [ADDR_W-1:0] RESET_PC    = 8'h00;
    localparam logic [3:0]        STOP_OPCODE = 4'b0001;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO of fetch entries that absorbs decode stalls and read latency.
module fetch_skid_fifo
    import fetch_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [ENTRY_W-1:0] entry_i,
    output logic [ENTRY_W-1:0] head_o,
    output logic [1:0]         count_o
);

    logic [ENTRY_W-1:0] mem_q [2];
    logic               rd_ptr_q;
    logic               wr_ptr_q;
    logic [1:0]         count_q;
    logic [1:0]         count_d;
    logic               do_push;
    logic               do_pop;

    always_comb begin
        do_push = push_i && (count_q != 2'd2);
        do_pop  = pop_i && (count_q != 2'd0);
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset: entries are only ever read below count_q.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= entry_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC/issue control, in-flight tracking, skid buffer,
// bypass path into IR1, STOP handling and the delivered-instruction counter.
module fetch_stage
    import fetch_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_q,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [INSTR_W-1:0] ir1,
    output logic [ADDR_W-1:0]  ir1_pc,
    output logic               ir1_valid,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
    logic               inflight_q, inflight_d;
    logic               stop_seen_q, stop_seen_d;
    logic [INSTR_W-1:0] ir1_q, ir1_d;
    logic [ADDR_W-1:0]  ir1_pc_q, ir1_pc_d;
    logic               ir1_valid_q, ir1_valid_d;
    logic [15:0]        count_q, count_d;

    logic [1:0]         buf_count;
    logic               buf_empty;
    logic               ret_valid;
    logic               fifo_push;
    logic               fifo_pop;
    logic               ir1_load;
    logic               issue;
    logic [ENTRY_W-1:0] head_bits;
    fetch_entry_t       ret_entry;
    fetch_entry_t       head_entry;
    fetch_entry_t       load_entry;

    fetch_skid_fifo u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .flush_i (redirect),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .entry_i (ret_entry),
        .head_o  (head_bits),
        .count_o (buf_count)
    );

    always_comb begin
        ret_entry.pc    = req_pc_q;
        ret_entry.instr = imem_q;
        head_entry      = fetch_entry_t'(head_bits);
        buf_empty       = (buf_count == 2'd0);
        // Anything returning after STOP was seen belongs to a later address.
        ret_valid       = inflight_q && !stop_seen_q;
        fifo_push       = ret_valid && !redirect && (stall || !buf_empty);
        fifo_pop        = !redirect && !stall && !buf_empty;
        ir1_load        = !redirect && !stall && (!buf_empty || ret_valid);
        load_entry      = buf_empty ? ret_entry : head_entry;
        // Credit check: buffered plus in-flight entries never exceed the buffer depth.
        issue           = !redirect && !stop_seen_q &&
                          (({1'b0, buf_count} + {2'b00, inflight_q}) < 3'd2);

        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        inflight_d  = issue;
        stop_seen_d = stop_seen_q;
        if (redirect) begin
            pc_d        = redirect_pc;
            stop_seen_d = 1'b0;
        end else begin
            if (issue) begin
                pc_d     = pc_q + ADDR_W'(1);
                req_pc_d = pc_q;
            end
            if (ret_valid && (imem_q[3:0] == STOP_OPCODE)) begin
                stop_seen_d = 1'b1;
            end
        end

        ir1_d       = ir1_q;
        ir1_pc_d    = ir1_pc_q;
        ir1_valid_d = ir1_valid_q;
        if (redirect) begin
            ir1_valid_d = 1'b0;
        end else if (!stall) begin
            ir1_valid_d = ir1_load;
            if (ir1_load) begin
                ir1_d    = load_entry.instr;
                ir1_pc_d = load_entry.pc;
            end
        end

        count_d = (ir1_load && (count_q != 16'hFFFF)) ? count_q + 16'd1 : count_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            inflight_q  <= 1'b0;
            stop_seen_q <= 1'b0;
            ir1_q       <= '0;
            ir1_pc_q    <= '0;
            ir1_valid_q <= 1'b0;
            count_q     <= 16'd0;
        end else begin
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            inflight_q  <= inflight_d;
            stop_seen_q <= stop_seen_d;
            ir1_q       <= ir1_d;
            ir1_pc_q    <= ir1_pc_d;
            ir1_valid_q <= ir1_valid_d;
            count_q     <= count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign ir1         = ir1_q;
    assign ir1_pc      = ir1_pc_q;
    assign ir1_valid   = ir1_valid_q;
    assign halted      = stop_seen_q & ~inflight_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a stream-level model of delivered instructions checked
// every cycle, plus hand-computed expectations for reset, stall, redirect, STOP and wrap.
module tb_fetch_stage;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] imem_addr;
    logic [7:0] imem_q;
    logic       stall;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic [7:0] ir1;
    logic [7:0] ir1_pc;
    logic       ir1_valid;
    logic       halted;
    logic [15:0] fetch_count;

    logic [7:0] mem [256];

    int errors = 0;
    int checks = 0;

    fetch_stage dut (
        .clock       (clock),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_q      (imem_q),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ir1         (ir1),
        .ir1_pc      (ir1_pc),
        .ir1_valid   (ir1_valid),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    always #5 clock = ~clock;

    // Synchronous-read instruction memory.
    always @(posedge clock) imem_q <= mem[imem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Inputs seen by the DUT at the most recent active edge.
    logic       e_reset    = 1'b0;
    logic       e_stall    = 1'b0;
    logic       e_redirect = 1'b0;
    logic [7:0] e_rpc      = 8'h00;

    always @(posedge clock) begin
        e_reset    = reset;
        e_stall    = stall;
        e_redirect = redirect;
        e_rpc      = redirect_pc;
    end

    // Model: after reset or redirect to T, IR1 delivers T, T+1, ... (mod 256), each carrying
    // mem[pc], until a STOP instruction has been delivered; stalls freeze IR1.
    bit          model_on  = 1'b0;
    bit          stopped   = 1'b0;
    logic [7:0]  exp_pc    = 8'h00;
    logic [15:0] exp_count = 16'd0;
    logic [7:0]  prev_ir1;
    logic [7:0]  prev_pc;
    logic        prev_valid;

    always @(negedge clock) begin
        if (e_reset) begin
            chk("m_rst_valid", {31'd0, ir1_valid}, 32'd0);
            chk("m_rst_count", {16'd0, fetch_count}, 32'd0);
            chk("m_rst_addr", {24'd0, imem_addr}, 32'd0);
            model_on  = 1'b1;
            stopped   = 1'b0;
            exp_pc    = 8'h00;
            exp_count = 16'd0;
        end else if (model_on) begin
            if (e_redirect) begin
                chk("m_redir_bubble", {31'd0, ir1_valid}, 32'd0);
                exp_pc  = e_rpc;
                stopped = 1'b0;
            end else if (e_stall) begin
                chk("m_stall_valid", {31'd0, ir1_valid}, {31'd0, prev_valid});
                chk("m_stall_ir1", {24'd0, ir1}, {24'd0, prev_ir1});
                chk("m_stall_pc", {24'd0, ir1_pc}, {24'd0, prev_pc});
            end else if (ir1_valid) begin
                chk("m_after_stop", {31'd0, stopped}, 32'd0);
                chk("m_ir1_pc", {24'd0, ir1_pc}, {24'd0, exp_pc});
                chk("m_ir1", {24'd0, ir1}, {24'd0, mem[exp_pc]});
                if (mem[exp_pc][3:0] == 4'b0001) stopped = 1'b1;
                exp_pc = exp_pc + 8'd1;
                if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
            end
            chk("m_count", {16'd0, fetch_count}, {16'd0, exp_count});
        end
        prev_ir1   = ir1;
        prev_pc    = ir1_pc;
        prev_valid = ir1_valid;
    end

    // Credit rule: the skid buffer must never be pushed while full.
    always @(posedge clock) begin
        if (model_on && !reset && dut.fifo_push && (dut.buf_count == 2'd2)) begin
            errors++;
            $display("FAIL credit: push with buffer count %0d, required < 2", dut.buf_count);
        end
    end

    initial begin
        // i + 0x10, but a low nibble of 1 would be STOP, so it is remapped to E.
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'(i + 16'h10);
            if (mem[i][3:0] == 4'h1) mem[i][3:0] = 4'hE;
        end
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
        step(2);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_ir1", {24'd0, ir1}, 32'd0);
        reset = 1'b0;

        // Start-up latency and straight-line stream.
        step(1);
        chk("t1_bubble", {31'd0, ir1_valid}, 32'd0);
        chk("t1_addr1", {24'd0, imem_addr}, 32'h01);
        step(1);
        chk("t1_valid", {31'd0, ir1_valid}, 32'd1);
        chk("t1_ir1_0", {24'd0, ir1}, 32'h10);
        chk("t1_pc_0", {24'd0, ir1_pc}, 32'h00);
        step(1);
        chk("t1_ir1_1", {24'd0, ir1}, 32'h1E);
        chk("t1_pc_1", {24'd0, ir1_pc}, 32'h01);
        step(1);
        chk("t1_ir1_2", {24'd0, ir1}, 32'h12);
        chk("t1_pc_2", {24'd0, ir1_pc}, 32'h02);
        step(1);
        chk("t2_pc_3", {24'd0, ir1_pc}, 32'h03);

        // Three-cycle stall at pc 03.
        stall = 1'b1;
        step(1);
        chk("t2_hold_a", {24'd0, ir1_pc}, 32'h03);
        step(1);
        chk("t2_addr_frz_a", {24'd0, imem_addr}, 32'h06);
        step(1);
        chk("t2_hold_c", {24'd0, ir1}, 32'h13);
        chk("t2_addr_frz_b", {24'd0, imem_addr}, 32'h06);
        chk("t2_count", {16'd0, fetch_count}, 32'd4);
        stall = 1'b0;
        step(1);
        chk("t2_rel_4", {24'd0, ir1_pc}, 32'h04);
        step(1);
        chk("t2_rel_5", {24'd0, ir1_pc}, 32'h05);
        step(1);
        chk("t2_rel_6", {24'd0, ir1_pc}, 32'h06);
        chk("t2_rel_6v", {31'd0, ir1_valid}, 32'd1);

        // Stall until the buffer is full, then redirect while still stalled.
        stall = 1'b1;
        step(2);
        redirect = 1'b1; redirect_pc = 8'h40;
        step(1);
        chk("t3_bubble_a", {31'd0, ir1_valid}, 32'd0);
        chk("t3_addr", {24'd0, imem_addr}, 32'h40);
        redirect = 1'b0; stall = 1'b0;
        step(1);
        chk("t3_bubble_b", {31'd0, ir1_valid}, 32'd0);
        step(1);
        chk("t3_pc", {24'd0, ir1_pc}, 32'h40);
        chk("t3_ir1", {24'd0, ir1}, 32'h50);
        chk("t3_count", {16'd0, fetch_count}, 32'd8);

        // Wrap from FE, continuing into a STOP placed at 05.
        mem[8'h05] = 8'h11;
        redirect = 1'b1; redirect_pc = 8'hFE;
        step(1);
        redirect = 1'b0;
        step(2);
        chk("t5_pc_fe", {24'd0, ir1_pc}, 32'hFE);
        chk("t5_ir1_fe", {24'd0, ir1}, 32'h0E);
        step(1);
        chk("t5_pc_ff", {24'd0, ir1_pc}, 32'hFF);
        step(1);
        chk("t5_pc_00", {24'd0, ir1_pc}, 32'h00);
        step(1);
        chk("t5_pc_01", {24'd0, ir1_pc}, 32'h01);
        step(4);
        chk("t4_stop_pc", {24'd0, ir1_pc}, 32'h05);
        chk("t4_stop_ir1", {24'd0, ir1}, 32'h11);
        chk("t4_not_halted", {31'd0, halted}, 32'd0);
        step(1);
        chk("t4_drop", {31'd0, ir1_valid}, 32'd0);
        chk("t4_halted", {31'd0, halted}, 32'd1);
        chk("t4_addr", {24'd0, imem_addr}, 32'h07);
        step(2);
        chk("t4_halted_hold", {31'd0, halted}, 32'd1);
        chk("t4_addr_hold", {24'd0, imem_addr}, 32'h07);
        redirect = 1'b1; redirect_pc = 8'h00;
        step(1);
        chk("t4_unhalt", {31'd0, halted}, 32'd0);
        redirect = 1'b0;
        step(2);
        chk("t4_refetch_pc", {24'd0, ir1_pc}, 32'h00);
        chk("t4_refetch_ir1", {24'd0, ir1}, 32'h10);
        chk("t4_count", {16'd0, fetch_count}, 32'd17);

        // Reset with one entry buffered and one request in flight.
        stall = 1'b1;
        step(1);
        reset = 1'b1; stall = 1'b0;
        step(1);
        chk("t6_ir1", {24'd0, ir1}, 32'd0);
        chk("t6_pc", {24'd0, ir1_pc}, 32'd0);
        chk("t6_valid", {31'd0, ir1_valid}, 32'd0);
        chk("t6_count", {16'd0, fetch_count}, 32'd0);
        chk("t6_addr", {24'd0, imem_addr}, 32'd0);
        reset = 1'b0;
        step(1);
        chk("t6_ignored", {31'd0, ir1_valid}, 32'd0);
        step(1);
        chk("t6_restart_pc", {24'd0, ir1_pc}, 32'h00);
        chk("t6_restart_ir1", {24'd0, ir1}, 32'h10);
        chk("t6_restart_cnt", {16'd0, fetch_count}, 32'd1);
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
